motoro3_pwm_drive: RTL and testbench
====================================

# motoro3_pwm_drive

Step sequencer and PWM generator that drives the step-indexed pulse-length lookup of the motoro3 three-phase motor path. The block presents `lcStep` to the length calculator, captures the returned `plLen`, and emits a fixed-period PWM waveform whose high time is that length. After a programmable number of periods it advances to the next step and wraps through the commutation sequence. It sits between the length calculator and the phase output stage.

## Interface
- `PERIOD`, 16'd20000: PWM period in `clk` cycles. Legal range is 2..65535.
- `STEP_MAX`, 4'd12: last step index. The sequence is 1..STEP_MAX; step 0 is reserved and is never issued while running.
- `clk`  input  1: system clock.
- `nRst`  input  1: asynchronous, active-low reset.
- `enable`  input  1: run request. It is level-sensitive.
- `repPerStep`  input  8: PWM periods per step. The value 0 is treated as 1.
- `plLen`  input  16: high time returned by the length calculator for the current `lcStep`.
- `lcStep`  output  4: step index presented to the length calculator.
- `pwmOut`  output  1: PWM waveform.
- `stepAdv`  output  1: one-cycle pulse when `lcStep` changes to a new running step.
- `busy`  output  1: high in every state other than IDLE.

## Operation
- Reset values: `lcStep`=0, `pwmOut`=0, `stepAdv`=0, `busy`=0, state IDLE. All internal counters reset to 0.
- **IDLE**
  - `lcStep`=0 and `pwmOut`=0.
  - When `enable`=1, go to LOAD with `lcStep`=1 and `busy`=1.
- **LOAD** (one cycle)
  - Hold `lcStep` stable.
  - Register `lenReg` = min(`plLen`, `PERIOD`). Clamping is required.
  - Register `repReg` = max(`repPerStep`, 1) - 1.
  - Clear `perCnt` and go to RUN.
- **RUN**
  - `perCnt` counts 0..PERIOD-1.
  - `pwmOut` is registered as (`perCnt` < `lenReg`). `lenReg`=0 gives constant low; `lenReg`=PERIOD gives constant high.
  - When `perCnt` = PERIOD-1 and `repCnt` < `repReg`: increment `repCnt`, wrap `perCnt` to 0, and stay in RUN. `lenReg` is not reloaded within a step.
  - When `perCnt` = PERIOD-1 and `repCnt` = `repReg`:
    - `lcStep` becomes `lcStep`+1, or 1 if `lcStep`=`STEP_MAX`.
    - Clear `repCnt`, pulse `stepAdv`, and go to LOAD.
- **Enable deassertion**
  - `enable` is sampled only at `perCnt` = PERIOD-1.
  - If it is 0 there, go to IDLE instead of advancing the step. `lcStep` returns to 0 and there is no `stepAdv` pulse.
  - A period in progress always completes, so there are no runt pulses.
- **Widths**
  - `perCnt` is 16 bits and `repCnt` is 8 bits.
  - The comparison is unsigned 16-bit.
  - The `lcStep` wrap uses 4-bit compare against `STEP_MAX`.
- **Asynchronous reset mid-period**: `pwmOut` drops to 0 immediately, and the block restarts from IDLE.

## Timing
- `plLen` is treated as a combinational function of `lcStep` with at most one cycle of settling.
- `lcStep` is stable for at least one full `clk` cycle before the LOAD capture edge.
- Start-up latency: `enable` rising → `busy` the next cycle → LOAD → first `pwmOut` high at cycle 3 after `enable` is sampled high (if `lenReg`>0).
- Per step: one LOAD cycle plus `repReg`+1 full periods. The LOAD cycle drives `pwmOut`=0.
- `stepAdv` is coincident with the cycle in which the new `lcStep` value is first driven.
- `pwmOut` is registered, with no glitches.

## Structure
- Shared package `motoro3_pkg`:
  - state enum IDLE/LOAD/RUN;
  - `MOTORO3_STEP_W`=4 and `MOTORO3_LEN_W`=16;
  - default `PERIOD` and `STEP_MAX` constants, shared with the length calculator.
- One natural sub-module, `motoro3_pwm_cmp`: the period counter and compare, with period-end flag and registered `pwmOut`. The step/rep sequencing stays in the top.

## Test plan
- **Reset and idle**: hold `nRst`=0, then release with `enable`=0 for 100 cycles → all outputs 0, `lcStep`=0.
- **Basic step**: use `PERIOD`=100, `repPerStep`=2, and a bench model returning `plLen`=30 for step 1 and 60 for step 2 → two periods of 30 cycles high / 70 low, one LOAD cycle low, then 60 high / 40 low. `stepAdv` pulses once, at the step 1→2 change.
- **Clamp and extremes**: `plLen`=16'hFFFF with `PERIOD`=100 → `pwmOut` constantly high for the whole step. `plLen`=0 → constantly low.
- **Wrap**: use `STEP_MAX`=3 and `repPerStep`=0 → `lcStep` sequence 1,2,3,1,2; each step is one period long; step 0 never appears while `busy`.
- **Graceful stop**: drop `enable` at `perCnt`=20 of a 100-cycle period → that period completes unchanged, then IDLE with `lcStep`=0 and no `stepAdv`.
- **Reset mid-operation**: assert `nRst` while `pwmOut`=1 → `pwmOut`=0 in the same cycle. After release with `enable`=1, the block restarts at `lcStep`=1.

Source files
------------

// File: rtl/motoro3_pkg.sv
// Shared motoro3 types and constants: sequencer states, datapath widths, default
// PWM period and last commutation step, plus the pulse-length clamp helper.
package motoro3_pkg;

  localparam int MOTORO3_STEP_W = 4;
  localparam int MOTORO3_LEN_W  = 16;

  localparam logic [MOTORO3_LEN_W-1:0]  MOTORO3_PERIOD_DEF   = 16'd20000;
  localparam logic [MOTORO3_STEP_W-1:0] MOTORO3_STEP_MAX_DEF = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } motoro3_state_e;

  // A calculator result longer than the period would otherwise never let the compare go low.
  function automatic logic [MOTORO3_LEN_W-1:0] motoro3_clamp_len(
    input logic [MOTORO3_LEN_W-1:0] len,
    input logic [MOTORO3_LEN_W-1:0] period
  );
    return (len > period) ? period : len;
  endfunction

endpackage

// File: rtl/motoro3_pwm_cmp.sv
// Period counter and compare: counts 0..PERIOD-1 while run is high, flags the last
// count, and registers pwmOut one cycle behind the count it was compared against.
module motoro3_pwm_cmp
  import motoro3_pkg::*;
#(
  parameter logic [MOTORO3_LEN_W-1:0] PERIOD = MOTORO3_PERIOD_DEF
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     run,
  input  logic [MOTORO3_LEN_W-1:0] len,
  output logic                     per_end,
  output logic                     pwmOut
);

  localparam logic [MOTORO3_LEN_W-1:0] PER_LAST = PERIOD - 16'd1;

  logic [MOTORO3_LEN_W-1:0] per_cnt_q, per_cnt_d;
  logic                     pwm_q, pwm_d;

  assign per_end = run && (per_cnt_q == PER_LAST);
  assign pwmOut  = pwm_q;

  // Outside RUN the counter sits at 0 so the first period after LOAD starts cleanly.
  always_comb begin
    per_cnt_d = per_cnt_q;
    pwm_d     = 1'b0;
    if (!run || per_end) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_q + 16'd1;
    end
    if (run) begin
      pwm_d = (per_cnt_q < len);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      per_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

endmodule

// File: rtl/motoro3_pwm_drive.sv
// Step sequencer: presents lcStep, captures the clamped plLen in LOAD, runs repPerStep
// PWM periods per step, then wraps through 1..STEP_MAX; enable is honoured at period ends.
module motoro3_pwm_drive
  import motoro3_pkg::*;
#(
  parameter logic [MOTORO3_LEN_W-1:0]  PERIOD   = MOTORO3_PERIOD_DEF,
  parameter logic [MOTORO3_STEP_W-1:0] STEP_MAX = MOTORO3_STEP_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic                      enable,
  input  logic [7:0]                repPerStep,
  input  logic [MOTORO3_LEN_W-1:0]  plLen,
  output logic [MOTORO3_STEP_W-1:0] lcStep,
  output logic                      pwmOut,
  output logic                      stepAdv,
  output logic                      busy
);

  motoro3_state_e            state_q, state_d;
  logic [MOTORO3_STEP_W-1:0] lc_step_q, lc_step_d;
  logic [MOTORO3_LEN_W-1:0]  len_q, len_d;
  logic [7:0]                rep_q, rep_d;
  logic [7:0]                rep_cnt_q, rep_cnt_d;
  logic                      step_adv_q, step_adv_d;
  logic                      per_end;

  motoro3_pwm_cmp #(
    .PERIOD (PERIOD)
  ) u_cmp (
    .clk     (clk),
    .nRst    (nRst),
    .run     (state_q == RUN),
    .len     (len_q),
    .per_end (per_end),
    .pwmOut  (pwmOut)
  );

  always_comb begin
    state_d    = state_q;
    lc_step_d  = lc_step_q;
    len_d      = len_q;
    rep_d      = rep_q;
    rep_cnt_d  = rep_cnt_q;
    step_adv_d = 1'b0;
    case (state_q)
      IDLE: begin
        lc_step_d = '0;
        if (enable) begin
          state_d   = LOAD;
          lc_step_d = 4'd1;
        end
      end
      LOAD: begin
        len_d     = motoro3_clamp_len(plLen, PERIOD);
        rep_d     = (repPerStep == 8'd0) ? 8'd0 : repPerStep - 8'd1;
        rep_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        // Only period ends are decision points, so every started period finishes.
        if (per_end) begin
          if (!enable) begin
            state_d   = IDLE;
            lc_step_d = '0;
            rep_cnt_d = '0;
          end else if (rep_cnt_q < rep_q) begin
            rep_cnt_d = rep_cnt_q + 8'd1;
          end else begin
            rep_cnt_d  = '0;
            lc_step_d  = (lc_step_q == STEP_MAX) ? 4'd1 : lc_step_q + 4'd1;
            step_adv_d = 1'b1;
            state_d    = LOAD;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        lc_step_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      lc_step_q  <= '0;
      len_q      <= '0;
      rep_q      <= '0;
      rep_cnt_q  <= '0;
      step_adv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lc_step_q  <= lc_step_d;
      len_q      <= len_d;
      rep_q      <= rep_d;
      rep_cnt_q  <= rep_cnt_d;
      step_adv_q <= step_adv_d;
    end
  end

  assign lcStep  = lc_step_q;
  assign stepAdv = step_adv_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_motoro3_pwm_drive.sv
// Bench for motoro3_pwm_drive with PERIOD=100 and STEP_MAX=3: per-cycle comparison
// against an expected waveform built from step/period arithmetic.
module tb_motoro3_pwm_drive;

  localparam int P    = 100;
  localparam int SMAX = 3;
  localparam int MAXC = 2048;

  logic        clk;
  logic        nRst;
  logic        enable;
  logic [7:0]  repPerStep;
  logic [15:0] plLen;
  logic [3:0]  lcStep;
  logic        pwmOut;
  logic        stepAdv;
  logic        busy;

  logic [15:0] len_tab [0:15];

  int errors = 0;
  int checks = 0;

  int e_pwm  [MAXC];
  int e_step [MAXC];
  int e_adv  [MAXC];
  int e_busy [MAXC];

  motoro3_pwm_drive #(
    .PERIOD   (16'd100),
    .STEP_MAX (4'd3)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .enable     (enable),
    .repPerStep (repPerStep),
    .plLen      (plLen),
    .lcStep     (lcStep),
    .pwmOut     (pwmOut),
    .stepAdv    (stepAdv),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Length calculator stand-in: a pure lookup on the presented step.
  always_comb plLen = len_tab[lcStep];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int p, input int s, input int a, input int b);
    chk({tag, "_pwm"},  16'(pwmOut),  16'(p));
    chk({tag, "_step"}, 16'(lcStep),  16'(s));
    chk({tag, "_adv"},  16'(stepAdv), 16'(a));
    chk({tag, "_busy"}, 16'(busy),    16'(b));
  endtask

  // Starts from IDLE at posedge+1, runs nsteps steps, drops enable at count 20 of the
  // final period, and checks every cycle until the block is back in IDLE.
  task automatic run_and_check(input string tag, input int nsteps);
    int reps, c, s, ln, total, drop_cyc;
    for (int i = 0; i < MAXC; i++) begin
      e_pwm[i] = 0; e_step[i] = 0; e_adv[i] = 0; e_busy[i] = 0;
    end
    reps = (repPerStep == 8'd0) ? 1 : int'(repPerStep);
    c = 0;
    drop_cyc = 0;
    for (int i = 0; i < nsteps; i++) begin
      s  = (i % SMAX) + 1;
      ln = (int'(len_tab[s]) > P) ? P : int'(len_tab[s]);
      e_step[c] = s; e_busy[c] = 1; e_adv[c] = (i > 0) ? 1 : 0;
      for (int k = 0; k < reps * P; k++) begin
        e_step[c + 1 + k] = s;
        e_busy[c + 1 + k] = 1;
        e_pwm[c + 2 + k]  = ((k % P) < ln) ? 1 : 0;
      end
      drop_cyc = c + 1 + (reps - 1) * P + 20;
      c = c + 1 + reps * P;
    end
    total = c + 2;
    enable = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < total; t++) begin
      chk_all(tag, e_pwm[t], e_step[t], e_adv[t], e_busy[t]);
      if (t == drop_cyc) enable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int found;
    nRst = 1'b0;
    enable = 1'b0;
    repPerStep = 8'd0;
    for (int i = 0; i < 16; i++) len_tab[i] = 16'd0;

    // Reset and idle
    #12;
    chk_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      chk_all("idle", 0, 0, 0, 0);
      @(posedge clk); #1;
    end

    // Basic step, ending with a graceful stop mid-period of step 2
    len_tab[1] = 16'd30; len_tab[2] = 16'd60; len_tab[3] = 16'd45;
    repPerStep = 8'd2;
    run_and_check("basic", 2);

    // Clamp and extremes: oversize, zero, exactly PERIOD
    len_tab[1] = 16'hFFFF; len_tab[2] = 16'd0; len_tab[3] = 16'd100;
    repPerStep = 8'd1;
    run_and_check("clamp", 3);

    // Wrap with repPerStep=0 treated as one period per step
    for (int i = 1; i <= SMAX; i++) len_tab[i] = 16'($urandom_range(0, 130));
    repPerStep = 8'd0;
    run_and_check("wrap", 5);

    // Graceful stop inside the third period of a single step
    len_tab[1] = 16'd70;
    repPerStep = 8'd3;
    run_and_check("stop", 1);

    // Randomized lengths, repeat counts and run lengths
    for (int r = 0; r < 4; r++) begin
      for (int i = 1; i <= SMAX; i++) len_tab[i] = 16'($urandom_range(0, 130));
      if ($urandom_range(0, 3) == 0) len_tab[$urandom_range(1, SMAX)] = 16'($urandom);
      repPerStep = 8'($urandom_range(0, 3));
      run_and_check("rand", int'($urandom_range(1, 4)));
    end

    // Reset mid-operation while pwmOut is high
    len_tab[1] = 16'd50;
    repPerStep = 8'd1;
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(posedge clk); #1;
      if (pwmOut === 1'b1) found = 1;
    end
    chk("rst_found_high", 16'(found), 16'd1);
    #2;
    nRst = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0);
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_restart", 0, 1, 0, 1);
    @(posedge clk); #1;
    chk_all("rst_run", 0, 1, 0, 1);
    enable = 1'b0;
    nRst = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_end", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
